mant_mul_arbiter: RTL and testbench
===================================

# mant_mul_arbiter

Round-robin scheduler that shares one pipelined 11x11 mantissa multiplier among N_REQ FP16 MAC lanes. Accepts one operand pair per cycle from the winning lane, registers it onto the multiplier inputs, and carries a valid/ID tag alongside the multiplier latency. The returned 22-bit product is tagged with the originating lane. It sits between the MAC lane front-ends (exponent/sign handling) and the shared mantissa multiplier.

## Interface
- N_REQ, 4: number of requesting lanes (2..8); IDW = clog2(N_REQ).
- MUL_LAT, 2: cycles from operands stable on mul_a/mul_b to the product on mul_p (fixed multiplier latency, >=1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  lane i has an operand pair.
- req_ready  out  N_REQ  one-hot grant, combinational; handshake = req_valid[i] & req_ready[i].
- req_a  in  N_REQ*11  packed mantissas (hidden bit included), lane i at [11i+10:11i].
- req_b  in  N_REQ*11  packed mantissas, same packing.
- mul_a  out  11  registered operand A to multiplier.
- mul_b  out  11  registered operand B to multiplier.
- mul_p  in  22  multiplier product.
- rsp_valid  out  1  one-cycle pulse, product available.
- rsp_id  out  IDW  lane that issued the product.
- rsp_m  out  22  registered product.
- pend  out  N_REQ  lane i has an operation in flight.
- idle  out  1  high when pend == 0 and no rsp_valid.

## Operation
- Eligible lane: req_valid[i] & ~pend[i]. At most one grant per cycle.
- Round-robin: pointer ptr (IDW bits) = search start; grant first eligible lane at ptr, ptr+1, ... wrapping mod N_REQ. On handshake for lane g, ptr <= (g+1) mod N_REQ. No handshake: ptr unchanged.
- req_ready depends combinationally on req_valid, pend, ptr; lanes must not derive req_valid from req_ready. Lanes hold req_a/req_b stable while req_valid is high and unserved.
- On handshake: mul_a/mul_b <= lane operands; issue tag {1, g} enters tag pipeline; pend[g] <= 1.
- No handshake: mul_a/mul_b hold previous value; tag valid bit 0 enters pipeline.
- Tag pipeline: MUL_LAT+1 stages of {vld, id}; output stage aligned with the cycle mul_p holds that issue's product.
- Capture: when output tag valid, rsp_m <= mul_p, rsp_id <= tag id, rsp_valid <= 1, pend[id] <= 0 on the same edge. Otherwise rsp_valid <= 0; rsp_m/rsp_id hold.
- No backpressure on response; consumers must take rsp when rsp_valid=1.
- Per lane at most one outstanding op, so per-lane ordering is trivial; across lanes responses return in issue order.
- Products are not checked or modified (pure pass-through of mul_p, 22 bits, unsigned).

## Timing
- Reset (rst_n low, async): mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_m=0, pend=0, ptr=0, all tag valids 0; req_ready=0 while reset asserted; idle=1.
- Handshake in cycle T -> mul_a/mul_b valid T+1 -> mul_p valid T+1+MUL_LAT -> rsp_valid high in T+2+MUL_LAT (default 4 cycles after T).
- pend[g] high from T+1 through T+1+MUL_LAT; low in cycle T+2+MUL_LAT, so lane g may handshake again in the same cycle its rsp_valid is high. Per-lane rate 1/(MUL_LAT+2); aggregate 1/cycle.
- Reset mid-operation: all in-flight tags discarded; no rsp_valid for them after rst_n rises even though the multiplier still produces outputs.
- First grant after reset is lane 0 if eligible.

## Test plan
- Single lane: lane 1 req_a=11'h400, req_b=11'h400 at T -> mul_a=11'h400 at T+1, rsp_valid at T+4 with rsp_id=1, rsp_m=22'h100000; pend[1] high T+1..T+3.
- All four lanes valid at T (lane i operands 11'h600,11'h600 / 11'h7FF,11'h7FF / 11'h400,11'h600 / 11'h500,11'h400) -> grants lanes 0,1,2,3 in T..T+3; responses T+4..T+7 with rsp_m 22'h240000, 22'h3FF001, 22'h180000, 22'h140000.
- Lane 2 held valid continuously alone -> handshakes at T, T+4, T+8; req_ready[2]=0 in between.
- Lanes 0 and 3 held valid continuously -> alternating grants 0,3,0,3; no lane starved; each lane one result per 4 cycles.
- rst_n pulsed low at T+2 after handshake at T -> outputs zero immediately; no rsp_valid in following 10 cycles; idle=1; next grant lane 0.
- Lane 0 re-requests in its rsp_valid cycle -> handshake accepted that cycle, new rsp 4 cycles later, rsp_id=0.

Source files
------------

// File: rtl/mant_mul_arbiter.sv
// mant_mul_arbiter
//   Round-robin scheduler sharing one pipelined 11x11 mantissa multiplier
//   among N_REQ FP16 MAC lanes. One operand pair is accepted per cycle from
//   the winning lane and registered onto mul_a/mul_b. A {valid,id} tag rides
//   alongside the multiplier latency so the returned product can be steered
//   back to its lane.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid[N_REQ]    lane i has an operand pair
//   req_ready[N_REQ]    one-hot combinational grant
//   req_a/req_b         packed 11-bit mantissas, lane i at [11i+10:11i]
//   mul_a/mul_b         registered operands to the shared multiplier
//   mul_p               multiplier product, MUL_LAT cycles after mul_a/mul_b
//   rsp_valid/id/m      one-cycle product pulse, lane tag, registered product
//   pend[N_REQ]         lane i has an operation in flight
//   idle                nothing in flight and no response this cycle

// Per-lane in-flight flag. A lane is only eligible while it has nothing
// outstanding, which keeps per-lane ordering trivially correct.
module mant_mul_arbiter_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic set,
    input  logic clr,
    input  logic req_valid,
    output logic pend,
    output logic elig
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   pend <= 1'b0;
        else if (set) pend <= 1'b1;
        else if (clr) pend <= 1'b0;
    end

    assign elig = req_valid & ~pend;
endmodule

module mant_mul_arbiter #(
    parameter  int N_REQ   = 4,
    parameter  int MUL_LAT = 2,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*11-1:0]  req_a,
    input  logic [N_REQ*11-1:0]  req_b,
    output logic [10:0]          mul_a,
    output logic [10:0]          mul_b,
    input  logic [21:0]          mul_p,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [21:0]          rsp_m,
    output logic [N_REQ-1:0]     pend,
    output logic                 idle
);
    logic [N_REQ-1:0]            elig;
    logic [N_REQ-1:0]            grant_oh;
    logic [N_REQ-1:0]            clr_oh;
    logic [IDW-1:0]              ptr;
    logic [IDW-1:0]              gnt_id;
    logic                        found;
    logic [IDW:0]                idx;
    logic                        hs;
    logic [10:0]                 a_sel;
    logic [10:0]                 b_sel;

    // Tag pipeline: stage 0 is loaded on the issue edge, stage MUL_LAT lines
    // up with the cycle mul_p carries that issue's product.
    logic [MUL_LAT:0]            vld_pipe;
    logic [MUL_LAT:0][IDW-1:0]   id_pipe;

    // Search from ptr upward, wrapping mod N_REQ; first eligible lane wins.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) idx = idx - (IDW+1)'(N_REQ);
            if (!found && elig[idx[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = idx[IDW-1:0];
            end
        end
    end

    // Grant is suppressed while reset is held so no lane sees a handshake
    // that the (reset) datapath would drop.
    always_comb begin
        grant_oh = '0;
        if (found && rst_n) grant_oh[gnt_id] = 1'b1;
    end

    assign req_ready = grant_oh;
    assign hs        = |grant_oh;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                a_sel = a_sel | req_a[i*11 +: 11];
                b_sel = b_sel | req_b[i*11 +: 11];
            end
        end
    end

    always_comb begin
        clr_oh = '0;
        if (vld_pipe[MUL_LAT]) clr_oh[id_pipe[MUL_LAT]] = 1'b1;
    end

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_lane
            mant_mul_arbiter_lane u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .set       (grant_oh[i]),
                .clr       (clr_oh[i]),
                .req_valid (req_valid[i]),
                .pend      (pend[i]),
                .elig      (elig[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[MUL_LAT-1:0], hs};
            id_pipe  <= {id_pipe[MUL_LAT-1:0], gnt_id};
            if (hs) begin
                mul_a <= a_sel;
                mul_b <= b_sel;
                ptr   <= (gnt_id == IDW'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_m     <= '0;
        end else begin
            rsp_valid <= vld_pipe[MUL_LAT];
            if (vld_pipe[MUL_LAT]) begin
                rsp_id <= id_pipe[MUL_LAT];
                rsp_m  <= mul_p;
            end
        end
    end

    assign idle = ~|pend & ~rsp_valid;
endmodule

// File: tb/tb_mant_mul_arbiter.sv
// Bench for mant_mul_arbiter: a cycle-count reference model (issue cycle per
// lane, queue of expected responses) checks every output on every negedge,
// and directed scenarios pin the model with hand-computed literals.
module tb_mant_mul_arbiter;
    localparam int N   = 4;
    localparam int L   = 2;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*11-1:0]   req_a = '0;
    logic [N*11-1:0]   req_b = '0;
    logic [10:0]       mul_a, mul_b;
    logic [21:0]       mul_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [21:0]       rsp_m;
    logic [N-1:0]      pend;
    logic              idle;

    always #5 clk = ~clk;

    mant_mul_arbiter #(.N_REQ(N), .MUL_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_m(rsp_m),
        .pend(pend), .idle(idle)
    );

    // Shared multiplier: free-running, not reset, L cycles of latency.
    logic [21:0] p_pipe [L];
    always @(posedge clk) begin
        p_pipe[0] <= 22'(mul_a) * 22'(mul_b);
        for (int k = 1; k < L; k++) p_pipe[k] <= p_pipe[k-1];
    end
    assign mul_p = p_pipe[L-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int c; int id; logic [21:0] m; } ev_t;
    ev_t          rsp_q[$];
    ev_t          gnt_log[$];
    ev_t          rsp_log[$];
    int           hs_cyc [N];
    int           ptr_m;
    int           g;
    logic [10:0]  exp_ma, exp_mb;
    int           last_id;
    logic [21:0]  last_m;
    logic [N-1:0] m_pend, m_elig, m_go;
    logic         m_rv;
    logic [N-1:0] mdl_hs_vec = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            ptr_m = 0;
            for (int i = 0; i < N; i++) hs_cyc[i] = -100;
            rsp_q.delete();
            last_id = 0; last_m = '0; exp_ma = '0; exp_mb = '0;
            mdl_hs_vec = '0;
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_pend", pend, 0);
            chk("rst_mul_a", mul_a, 0);
            chk("rst_mul_b", mul_b, 0);
            chk("rst_rsp_m", rsp_m, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_idle", idle, 1);
        end else begin
            // A lane is busy from the cycle after its issue through issue+1+L.
            for (int i = 0; i < N; i++) m_pend[i] = (cyc <= hs_cyc[i] + 1 + L);
            m_rv = 1'b0;
            if (rsp_q.size() > 0 && rsp_q[0].c == cyc) begin
                m_rv = 1'b1; last_id = rsp_q[0].id; last_m = rsp_q[0].m;
                rsp_q.delete(0);
            end
            chk("rsp_valid", rsp_valid, m_rv);
            chk("rsp_id", rsp_id, last_id);
            chk("rsp_m", rsp_m, last_m);
            chk("pend", pend, m_pend);
            chk("mul_a", mul_a, exp_ma);
            chk("mul_b", mul_b, exp_mb);
            chk("idle", idle, (m_pend == '0) && !m_rv);

            m_elig = req_valid & ~m_pend;
            m_go = '0;
            g = -1;
            for (int k = 0; k < N; k++)
                if (g < 0 && m_elig[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            if (g >= 0) m_go[g] = 1'b1;
            chk("req_ready", req_ready, m_go);
            mdl_hs_vec = m_go;
            if (g >= 0) begin
                hs_cyc[g] = cyc;
                exp_ma = req_a[g*11 +: 11];
                exp_mb = req_b[g*11 +: 11];
                rsp_q.push_back('{cyc + 2 + L, g, 22'(exp_ma) * 22'(exp_mb)});
                ptr_m = (g + 1) % N;
            end

            // Observed events, used by the directed literal checks.
            if (rsp_valid) rsp_log.push_back('{cyc, int'(rsp_id), rsp_m});
            for (int i = 0; i < N; i++)
                if (req_valid[i] && req_ready[i]) gnt_log.push_back('{cyc, i, '0});
        end
    end

    // ---------------- stimulus ----------------
    logic        want [N];
    logic        hold [N];
    logic [10:0] aa [N];
    logic [10:0] bb [N];

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req_valid[i]      = want[i];
            req_a[i*11 +: 11] = aa[i];
            req_b[i*11 +: 11] = bb[i];
        end
    endtask

    // Advance one cycle; served lanes drop unless held, held lanes get new operands.
    task automatic step();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (mdl_hs_vec[i]) begin
                if (!hold[i]) want[i] = 1'b0;
                else begin
                    aa[i] = 11'($urandom_range(0, 2047));
                    bb[i] = 11'($urandom_range(0, 2047));
                end
            end
        end
        apply();
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin want[i] = 1'b0; hold[i] = 1'b0; end
        apply();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_log.delete();
        rsp_log.delete();
    endtask

    task automatic ck_gnt(string nm, int k, int c, int id);
        if (k >= gnt_log.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: grant %0d missing, got %0d grants", nm, k, gnt_log.size());
        end else begin
            chk({nm, "_cyc"}, gnt_log[k].c, c);
            chk({nm, "_lane"}, gnt_log[k].id, id);
        end
    endtask

    task automatic ck_rsp(string nm, int k, int c, int id, logic [21:0] m);
        if (k >= rsp_log.size()) begin
            n_vec++; n_err++;
            $display("FAIL %s: response %0d missing, got %0d responses", nm, k, rsp_log.size());
        end else begin
            chk({nm, "_cyc"}, rsp_log[k].c, c);
            chk({nm, "_id"}, rsp_log[k].id, id);
            chk({nm, "_m"}, rsp_log[k].m, m);
        end
    endtask

    int t0;

    initial begin
        for (int i = 0; i < N; i++) begin
            want[i] = 1'b0; hold[i] = 1'b0; aa[i] = '0; bb[i] = '0;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single lane 1, 400h x 400h
        do_reset();
        want[1] = 1'b1; aa[1] = 11'h400; bb[1] = 11'h400; apply();
        t0 = cyc + 1;
        step();
        chk("t1_mul_a", mul_a, 11'h400);
        chk("t1_pend_t1", pend, 4'b0010);
        steps(2);
        chk("t1_pend_t3", pend, 4'b0010);
        step();
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_m", rsp_m, 22'h100000);
        chk("t1_pend_t4", pend, 4'b0000);
        steps(2);
        ck_gnt("t1_g0", 0, t0, 1);
        ck_rsp("t1_r0", 0, t0 + 4, 1, 22'h100000);

        // 2: all four lanes at once
        do_reset();
        aa[0] = 11'h600; bb[0] = 11'h600;
        aa[1] = 11'h7FF; bb[1] = 11'h7FF;
        aa[2] = 11'h400; bb[2] = 11'h600;
        aa[3] = 11'h500; bb[3] = 11'h400;
        for (int i = 0; i < N; i++) want[i] = 1'b1;
        apply();
        t0 = cyc + 1;
        steps(10);
        for (int i = 0; i < N; i++) ck_gnt("t2_g", i, t0 + i, i);
        ck_rsp("t2_r0", 0, t0 + 4, 0, 22'h240000);
        ck_rsp("t2_r1", 1, t0 + 5, 1, 22'h3FF001);
        ck_rsp("t2_r2", 2, t0 + 6, 2, 22'h180000);
        ck_rsp("t2_r3", 3, t0 + 7, 3, 22'h140000);

        // 3: lane 2 held alone -> one issue every 4 cycles
        do_reset();
        want[2] = 1'b1; hold[2] = 1'b1; apply();
        t0 = cyc + 1;
        steps(10);
        chk("t3_ngrants", gnt_log.size(), 3);
        for (int k = 0; k < 3; k++) ck_gnt("t3_g", k, t0 + 4*k, 2);

        // 4: lanes 0 and 3 held -> 0,3,0,3
        do_reset();
        want[0] = 1'b1; hold[0] = 1'b1; want[3] = 1'b1; hold[3] = 1'b1; apply();
        t0 = cyc + 1;
        steps(12);
        ck_gnt("t4_g0", 0, t0,     0);
        ck_gnt("t4_g1", 1, t0 + 1, 3);
        ck_gnt("t4_g2", 2, t0 + 4, 0);
        ck_gnt("t4_g3", 3, t0 + 5, 3);

        // 5: reset pulsed two cycles after an issue
        do_reset();
        want[1] = 1'b1; aa[1] = 11'h7FF; bb[1] = 11'h7FF; apply();
        steps(2);
        rst_n = 1'b0;
        #1;
        chk("t5_mul_a", mul_a, 0);
        chk("t5_pend", pend, 0);
        chk("t5_req_ready", req_ready, 0);
        chk("t5_idle", idle, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        gnt_log.delete(); rsp_log.delete();
        steps(10);
        chk("t5_no_rsp", rsp_log.size(), 0);
        chk("t5_idle_after", idle, 1);
        want[0] = 1'b1; want[2] = 1'b1; apply();
        step();
        ck_gnt("t5_first", 0, cyc, 0);

        // 6: lane 0 re-requests in its response cycle
        do_reset();
        want[0] = 1'b1; aa[0] = 11'h600; bb[0] = 11'h600; apply();
        t0 = cyc + 1;
        steps(4);
        want[0] = 1'b1; aa[0] = 11'h7FF; bb[0] = 11'h400; apply();
        steps(6);
        ck_gnt("t6_g1", 1, t0 + 4, 0);
        ck_rsp("t6_r0", 0, t0 + 4, 0, 22'h240000);
        ck_rsp("t6_r1", 1, t0 + 8, 0, 22'h1FFC00);

        // 7: random traffic with occasional resets
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                    hold[i] = ($urandom_range(0, 4) == 0);
                    aa[i] = 11'($urandom_range(0, 2047));
                    bb[i] = 11'($urandom_range(0, 2047));
                end else if (want[i] && hold[i] && $urandom_range(0, 15) == 0) begin
                    hold[i] = 1'b0;
                end
            end
            apply();
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        do_reset();
        steps(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
